// File: rtl/shift_register_piso.sv
// rtl/shift_register_piso.sv - parallel-in serial-out shift register with valid/last framing
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   load       request to accept D (honoured only while ready = 1)
//   D          n-bit parallel word
//   direction  bit order captured on accept: 0 = LSB-first, 1 = MSB-first
//   ready      word can be accepted this cycle (from state and last only)
//   O          serial data bit (registered)
//   valid      O carries a data bit (registered)
//   last       O carries the final bit of the word (registered)
//   done       one-cycle pulse after a frame ends with no follow-on word (registered)
module shift_register_piso #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] D,
    input  logic         direction,
    output logic         ready,
    output logic         O,
    output logic         valid,
    output logic         last,
    output logic         done
);

    localparam int CW = $clog2(n);
    // cnt value while the second-to-last bit is on O; the next step raises last.
    localparam logic [CW-1:0] CNT_PENULT = CW'(n - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_d;
    logic [n-1:0]  sr, sr_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          o_d, valid_d, last_d, done_d;
    logic          accept;

    // A new word may overlap the final bit of the current one, which is
    // what lets back-to-back words stream without an idle cycle.
    assign ready  = (state == IDLE) || (state == SHIFT && last);
    assign accept = load && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            dir_q <= 1'b0;
            cnt   <= '0;
            O     <= 1'b0;
            valid <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            sr    <= sr_d;
            dir_q <= dir_d;
            cnt   <= cnt_d;
            O     <= o_d;
            valid <= valid_d;
            last  <= last_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        sr_d    = sr;
        dir_d   = dir_q;
        cnt_d   = cnt;
        o_d     = O;
        valid_d = valid;
        last_d  = last;
        done_d  = 1'b0;

        if (accept) begin
            state_d = SHIFT;
            sr_d    = D;
            dir_d   = direction;
            cnt_d   = '0;
            o_d     = direction ? D[n-1] : D[0];
            valid_d = 1'b1;
            last_d  = 1'b0;
        end else if (state == SHIFT) begin
            if (last) begin
                state_d = IDLE;
                o_d     = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                // sr keeps the bit currently on O at its output end, so the
                // next bit is its neighbour one position inward.
                if (dir_q) begin
                    sr_d = {sr[n-2:0], 1'b0};
                    o_d  = sr[n-2];
                end else begin
                    sr_d = {1'b0, sr[n-1:1]};
                    o_d  = sr[1];
                end
                cnt_d  = cnt + CW'(1);
                last_d = (cnt == CNT_PENULT);
            end
        end
    end

endmodule

// File: tb/tb_shift_register_piso.sv
// tb/tb_shift_register_piso.sv - self-checking bench for shift_register_piso
module tb_shift_register_piso;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [N-1:0] D;
    logic         direction;
    logic         ready;
    logic         O;
    logic         valid;
    logic         last;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    shift_register_piso #(.n(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .D         (D),
        .direction (direction),
        .ready     (ready),
        .O         (O),
        .valid     (valid),
        .last      (last),
        .done      (done)
    );

    task automatic push_word(input logic [N-1:0] w, input logic dir);
        exp_t x;
        for (int i = 0; i < N; i++) begin
            x.b = dir ? w[N-1-i] : w[i];
            x.l = (i == N - 1);
            sb.push_back(x);
        end
    endtask

    // Drive a one-cycle load; returns at the negedge after the accept edge.
    task automatic send(input logic [N-1:0] w, input logic dir);
        @(negedge clk);
        load = 1'b1;
        D = w;
        direction = dir;
        push_word(w, dir);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load = 1'b1;
        D = 8'hFF;
        direction = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({O, valid, last, done, ready} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_outputs: O/valid/last/done/ready=%b expected 00001",
                     {O, valid, last, done, ready});
        end
        reset = 1'b0;
        load = 1'b0;
        @(negedge clk);
        vectors++;
        if ({valid, ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_no_frame: valid/ready=%b expected 01", {valid, ready});
        end
    endtask

    task automatic test_lsb_first;
        logic [0:7] seq;
        seq = 8'b0100_1101;
        @(negedge clk);
        load = 1'b1;
        D = 8'b1011_0010;
        direction = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e.b = seq[i];
            e.l = (i == 7);
            sb.push_back(e);
        end
        @(negedge clk);
        load = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL lsb_extra c=%0d: O=%b with nothing expected", c, O);
                end else begin
                    e = sb.pop_front();
                    if ({O, last} !== {e.b, e.l}) begin
                        miscompares++;
                        $display("FAIL lsb_bit c=%0d: O/last=%b%b expected %b%b", c, O, last, e.b, e.l);
                    end
                end
            end
            vectors++;
            if ({valid, ready, done} !== {c <= 8, c >= 8, c == 9}) begin
                miscompares++;
                $display("FAIL lsb_ctrl c=%0d: valid/ready/done=%b%b%b expected %b%b%b",
                         c, valid, ready, done, c <= 8, c >= 8, c == 9);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL lsb_leftover: %0d bits not emitted, expected 0", sb.size());
        end
    endtask

    task automatic test_msb_first;
        send(8'b1011_0010, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL msb_extra c=%0d: O=%b with nothing expected", c, O);
                end else begin
                    e = sb.pop_front();
                    if ({O, last} !== {e.b, e.l}) begin
                        miscompares++;
                        $display("FAIL msb_bit c=%0d: O/last=%b%b expected %b%b", c, O, last, e.b, e.l);
                    end
                end
            end
            vectors++;
            if ({valid, ready, done} !== {c <= 8, c >= 8, c == 9}) begin
                miscompares++;
                $display("FAIL msb_ctrl c=%0d: valid/ready/done=%b%b%b expected %b%b%b",
                         c, valid, ready, done, c <= 8, c >= 8, c == 9);
            end
            if (c == 3) begin
                direction = ~direction;
                D = 8'h5A;
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL msb_leftover: %0d bits not emitted, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        send(8'hA5, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra c=%0d: O=%b with nothing expected", c, O);
                end else begin
                    e = sb.pop_front();
                    if ({O, last} !== {e.b, e.l}) begin
                        miscompares++;
                        $display("FAIL b2b_bit c=%0d: O/last=%b%b expected %b%b", c, O, last, e.b, e.l);
                    end
                end
            end
            vectors++;
            if ({valid, ready, done} !== {c <= 16, (c == 8) || (c >= 16), c == 17}) begin
                miscompares++;
                $display("FAIL b2b_ctrl c=%0d: valid/ready/done=%b%b%b expected %b%b%b",
                         c, valid, ready, done, c <= 16, (c == 8) || (c >= 16), c == 17);
            end
            if (c == 8) begin
                load = 1'b1;
                D = 8'h0F;
                direction = 1'b0;
                push_word(8'h0F, 1'b0);
            end else if (c == 9) begin
                load = 1'b0;
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_leftover: %0d bits not emitted, expected 0", sb.size());
        end
    endtask

    task automatic test_busy_load;
        send(8'h00, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            if (valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL busy_extra c=%0d: O=%b with nothing expected", c, O);
                end else begin
                    e = sb.pop_front();
                    if ({O, last} !== {e.b, e.l}) begin
                        miscompares++;
                        $display("FAIL busy_bit c=%0d: O/last=%b%b expected %b%b", c, O, last, e.b, e.l);
                    end
                end
            end
            vectors++;
            if ({valid, ready, done} !== {c <= 8, c >= 8, c == 9}) begin
                miscompares++;
                $display("FAIL busy_ctrl c=%0d: valid/ready/done=%b%b%b expected %b%b%b",
                         c, valid, ready, done, c <= 8, c >= 8, c == 9);
            end
            if (c == 3) begin
                load = 1'b1;
                D = 8'hFF;
            end else if (c == 4) begin
                load = 1'b0;
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL busy_leftover: %0d bits not emitted, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        send(8'hC3, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rst_extra c=%0d: O=%b with nothing expected", c, O);
                end else begin
                    e = sb.pop_front();
                    if ({O, last} !== {e.b, e.l}) begin
                        miscompares++;
                        $display("FAIL rst_bit c=%0d: O/last=%b%b expected %b%b", c, O, last, e.b, e.l);
                    end
                end
            end
            vectors++;
            if ({valid, ready, done} !== {c <= 4, c >= 5, 1'b0}) begin
                miscompares++;
                $display("FAIL rst_ctrl c=%0d: valid/ready/done=%b%b%b expected %b%b0",
                         c, valid, ready, done, c <= 4, c >= 5);
            end
            if (c == 4) begin
                reset = 1'b1;
            end else if (c == 5) begin
                reset = 1'b0;
                sb.delete();
            end
        end
        send(8'h96, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            if (valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rst_new_extra c=%0d: O=%b with nothing expected", c, O);
                end else begin
                    e = sb.pop_front();
                    if ({O, last} !== {e.b, e.l}) begin
                        miscompares++;
                        $display("FAIL rst_new_bit c=%0d: O/last=%b%b expected %b%b", c, O, last, e.b, e.l);
                    end
                end
            end
            vectors++;
            if ({valid, ready, done} !== {c <= 8, c >= 8, c == 9}) begin
                miscompares++;
                $display("FAIL rst_new_ctrl c=%0d: valid/ready/done=%b%b%b expected %b%b%b",
                         c, valid, ready, done, c <= 8, c >= 8, c == 9);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rst_new_leftover: %0d bits not emitted, expected 0", sb.size());
        end
    endtask

    task automatic test_random_words;
        logic [N-1:0] w;
        logic         dir;
        for (int k = 0; k < 4; k++) begin
            w = N'($urandom);
            dir = 1'($urandom_range(0, 1));
            send(w, dir);
            for (int c = 1; c <= 10; c++) begin
                if (c > 1) @(negedge clk);
                if (valid === 1'b1) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL rand_extra w=%h c=%0d: O=%b with nothing expected", w, c, O);
                    end else begin
                        e = sb.pop_front();
                        if ({O, last} !== {e.b, e.l}) begin
                            miscompares++;
                            $display("FAIL rand_bit w=%h dir=%b c=%0d: O/last=%b%b expected %b%b",
                                     w, dir, c, O, last, e.b, e.l);
                        end
                    end
                end
                vectors++;
                if ({valid, done} !== {c <= 8, c == 9}) begin
                    miscompares++;
                    $display("FAIL rand_ctrl c=%0d: valid/done=%b%b expected %b%b",
                             c, valid, done, c <= 8, c == 9);
                end
            end
            vectors++;
            if (sb.size() != 0) begin
                miscompares++;
                $display("FAIL rand_leftover: %0d bits not emitted, expected 0", sb.size());
                sb.delete();
            end
        end
    endtask

    initial begin
        test_reset;
        test_lsb_first;
        test_msb_first;
        test_back_to_back;
        test_busy_load;
        test_reset_mid_frame;
        test_random_words;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_register_piso.md
# shift_register_piso

Parallel-in, serial-out shift register: the transmit end of the serial link whose receive end is the `shift_register_2` serial-in, parallel-out block. It accepts an `n`-bit word on a load handshake and emits it one bit per clock on `O`, either LSB-first or MSB-first. A `valid`/`last` framing pair lets a downstream SIPO or a bench know which cycles carry data. Back-to-back words stream with no idle gap.

## Interface
- `n`, default 8: word width in bits; legal range n >= 2.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `load`  input  1  request to accept `D`; takes effect only when `ready` = 1.
- `D`  input  n  parallel word to transmit.
- `direction`  input  1  bit order, sampled only on accept: 0 = LSB-first, 1 = MSB-first.
- `ready`  output  1  block can accept a word this cycle (combinational from state).
- `O`  output  1  serial data bit (registered).
- `valid`  output  1  `O` carries a data bit this cycle (registered).
- `last`  output  1  `O` carries the final bit of the current word (registered).
- `done`  output  1  one-cycle pulse in the cycle after the final bit, when no new word was accepted (registered).

## Operation
- State: `IDLE`, `SHIFT`. Internal state: n-bit shift register `sr`, latched direction `dir_q`, bit counter `cnt` of width clog2(n).
- Reset (reset = 1 at a rising edge): state := `IDLE`, `sr` := 0, `cnt` := 0, `dir_q` := 0, `O` = 0, `valid` = 0, `last` = 0, `done` = 0. Reset takes priority over `load` and aborts any frame in progress; no further bits of that frame appear.
- `ready` = (state == `IDLE`) or (state == `SHIFT` and `last` = 1).
- Accept: occurs when `load` = 1 and `ready` = 1 at a rising edge. The block captures `D` into `sr` and `direction` into `dir_q`, sets `cnt` := 0, and enters `SHIFT`. `O` receives the first bit, which is D[0] if direction = 0 and D[n-1] if direction = 1. `valid` := 1. `last` := 1 only if n == 1, which is not legal, so `last` := 0.
- `SHIFT`, non-final bit (`last` = 0):
  - each edge, `sr` shifts toward the output end: right if `dir_q` = 0, left if `dir_q` = 1, with zero fill;
  - `O` := the next bit; `cnt` := `cnt` + 1;
  - `last` := (`cnt` + 1 == n-1).
- `SHIFT`, final bit (`last` = 1):
  - If accept also occurs, the new word starts immediately, exactly as in Accept above.
  - Otherwise: state := `IDLE`, `O` := 0, `valid` := 0, `last` := 0, `done` := 1.
- `done` is forced to 0 on every edge except the one described in the final-bit case above.
- `load` while `ready` = 0 is ignored; `D` is not captured and there is no error flag.
- Changes on `direction` or `D` during a frame have no effect; only the values at accept matter.
- Bit order is defined so that a receiver shifting in the matching direction reconstructs `D` after n bits.

## Timing
- Accept at edge k: the first bit is on `O` with `valid` = 1 from edge k through edge k+1. Bit i (i = 0..n-1) is present for the cycle following edge k+i.
- `last` = 1 during the cycle following edge k+n-1. `done` pulses for the cycle following edge k+n, unless a new accept occurred at k+n.
- Latency from accept to first bit: 1 cycle. Frame length: exactly n `valid` cycles. Throughput: one word per n cycles with back-to-back load.
- All outputs except `ready` are registered; `ready` depends on state and `last` only, never on `load`.

## Test plan
- Reset: hold reset for 2 cycles with load = 1 -> `O`/`valid`/`last`/`done` = 0 and `ready` = 1; no frame starts.
- LSB-first: n = 8, D = 8'b1011_0010, direction = 0, one-cycle load -> `O` = 0,1,0,0,1,1,0,1 on 8 consecutive `valid` cycles; `last` on the 8th bit; `done` on the next cycle; `ready` = 0 during bits 1-7.
- MSB-first: same D, direction = 1 -> `O` = 1,0,1,1,0,0,1,0. Toggling `direction` and `D` mid-frame -> sequence unchanged.
- Back-to-back: load 8'hA5 (LSB-first), then hold load with D = 8'h0F during the `last` cycle -> 16 contiguous `valid` cycles, `O` = 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0; `done` only after bit 16.
- Busy load ignored: load 8'hFF at bit 3 of an 8'h00 frame -> all 8 bits = 0, and no second frame follows.
- Reset mid-frame: assert reset after bit 4 -> `valid` = 0 at the next edge, no `done` pulse, `ready` = 1; a new load then transmits normally.
